qspi_slave_cmd_ctrl: RTL
========================

Name: qspi_slave_cmd_ctrl

Overview:
- Transaction controller for the QSPI slave byte datapath. It sits between the rx/tx byte streams (rx byte-ready pulse, tx byte-consumed pulse, synchronised select) and a single-port word-addressed byte memory.
- It parses a command byte and a big-endian address, then streams burst writes into memory, or prefetches read data for the tx shifter.
- It keeps sticky error status that the master can read over the bus.

Parameters:
- ADDR_BYTES, 2, number of address bytes after the command byte (1..3).
- AW, 16, memory address width; must be <= 8*ADDR_BYTES. Upper received bits are discarded.
- IDLE_BYTE, 8'hFF, value driven on tx_data when no read data is valid.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- sel  in  1  chip select, already synchronised to clk, active high.
- rx_valid  in  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  in  8  received byte.
- tx_ready  in  1  one-cycle pulse: current tx_data was loaded; the next byte must be stable within 4 clk.
- tx_data  out  8  byte offered to the tx shifter.
- tx_oe  out  1  requests data-line drive (read/status phase).
- mem_req  out  1  memory request, held high until mem_ack.
- mem_we  out  1  write strobe qualifier, valid with mem_req.
- mem_addr  out  AW  memory address.
- mem_wdata  out  8  write data.
- mem_ack  in  1  one-cycle completion pulse; mem_rdata is valid with it on reads.
- mem_rdata  in  8  read data.
- busy  out  1  high whenever state != IDLE.
- status  out  8  {5'b0, overrun, cmd_err, busy}.

Behaviour:
- Reset: resetn=0 sampled at posedge clk -> state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, tx_data=IDLE_BYTE, tx_oe=0, overrun=0, cmd_err=0. Reset overrides all other events in the same cycle.
- Commands: 8'h02 WRITE, 8'h03 READ, 8'h05 STATUS. Any other value is illegal.
- States: IDLE, CMD, ADDR, WR, RD_FETCH, RD_STREAM, STAT, DRAIN.
- IDLE -> CMD on rising sel.
- CMD, first rx_valid:
  - WRITE or READ -> ADDR (address counter=0).
  - STATUS -> STAT: tx_data=status snapshot, tx_oe=1.
  - illegal -> DRAIN, cmd_err<=1.
- ADDR: shift bytes in MSB first. On the ADDR_BYTES-th byte, load mem_addr from the low AW bits.
  - WRITE -> WR.
  - READ -> RD_FETCH: mem_req=1, mem_we=0, issued on the cycle after the last address byte.
- WR: each rx_valid latches mem_wdata and asserts mem_req with mem_we=1.
  - On mem_ack: drop mem_req, mem_addr+1 (wraps 2^AW-1 -> 0).
  - rx_valid while mem_req is high: byte dropped, overrun<=1, address unchanged.
- RD_FETCH: on mem_ack, tx_data<=mem_rdata, tx_oe=1, mem_addr+1 -> RD_STREAM.
- RD_STREAM: each tx_ready pulse issues the next read (prefetch). On mem_ack, tx_data updates.
  - tx_ready while a fetch is outstanding: overrun<=1, tx_data keeps its old value.
  - rx_valid in RD_STREAM is ignored.
- STAT: tx_data holds the snapshot. tx_ready pulses are ignored.
- DRAIN: ignore all bytes until deselect.
- Deselect (sel falling) in any non-IDLE state:
  - If mem_req is high, hold it until mem_ack, discard the result, then enter IDLE. Otherwise enter IDLE next cycle.
  - tx_oe=0 and tx_data=IDLE_BYTE on IDLE entry.
  - Leaving STAT clears overrun and cmd_err; they stay sticky otherwise.
- Simultaneous mem_ack and rx_valid in WR: the ack completes first, then the new byte is accepted in the same cycle (no overrun).
- Deselect before the address is complete: no memory access occurs.
- Reset mid-transaction with mem_req high: mem_req drops immediately; the memory side must tolerate an abandoned request.

Decomposition:
- Shared package qspi_pkg holds:
  - command constants CMD_WRITE=8'h02, CMD_READ=8'h03, CMD_STATUS=8'h05;
  - the state enum;
  - the status bit indices.
- One natural sub-module: qspi_addr_collector (byte counter plus shift register that yields the address and a done pulse). Everything else stays in the top FSM.

Test Plan:
- Write burst: sel, bytes 02 00 10 AA BB CC, deselect -> memory writes AA@0x0010, BB@0x0011, CC@0x0012; mem_req pulses exactly 3; status=0.
- Read burst: memory preset 0x0020=11, 0x0021=22, 0x0022=33; sel, 03 00 20, three tx_ready -> tx_data sequence 11, 22, 33; tx_oe high until deselect, then tx_data=FF.
- Wrap: write 02 FF FF 5A 5B -> 5A@0xFFFF, 5B@0x0000.
- Illegal then status: 07 01 02 then deselect; next transaction 05 -> tx_data=8'h03 (cmd_err, busy); the following status read -> 8'h01.
- Overrun: memory ack delayed 10 clk, rx bytes spaced 2 clk in WR -> second byte dropped, status bit2 set, address advances once per ack.
- Abort: deselect after 02 00 (address incomplete) -> no mem_req; deselect mid-write with mem_req pending -> FSM waits for mem_ack, then IDLE; resetn=0 mid-read -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI slave command controller: command opcodes,
// the transaction state encoding and the bit positions of the status byte.
package qspi_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR,
    ST_RD_FETCH,
    ST_RD_STREAM,
    ST_STAT,
    ST_DRAIN
  } state_e;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_CMD_ERR = 1;
  localparam int STAT_OVERRUN = 2;

endpackage

// File: rtl/qspi_addr_collector.sv
// Collects ADDR_BYTES big-endian address bytes. o_done pulses together with
// the last byte and o_addr is valid in that same cycle (low AW bits only).
module qspi_addr_collector #(
  parameter int ADDR_BYTES = 2,
  parameter int AW         = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_clear,
  input  logic          i_byte_valid,
  input  logic [7:0]    i_byte,
  output logic [AW-1:0] o_addr,
  output logic          o_done
);

  localparam int SW = 8 * ADDR_BYTES;

  logic [SW-1:0] r_shift;
  logic [1:0]    r_count;
  logic [SW-1:0] w_next;

  // The byte arriving now is the least significant one collected so far.
  assign w_next = (r_shift << 8) | SW'(i_byte);
  assign o_done = i_byte_valid && (r_count == 2'(ADDR_BYTES - 1));
  assign o_addr = AW'(w_next);

  // Shift in address bytes MSB first; restart the count after the last byte.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_byte_valid) begin
      r_shift <= w_next;
      r_count <= o_done ? 2'd0 : r_count + 2'd1;
    end
  end

endmodule

// File: rtl/qspi_slave_cmd_ctrl.sv
// QSPI slave transaction controller: decodes the command byte, collects the
// address, streams burst writes to memory or prefetches read data for the tx
// shifter, and keeps sticky overrun / command-error status.
//
// Handshakes: rx_valid and tx_ready are single-cycle pulses that are acted on
// in the cycle they are high and never back-pressured. mem_req is held high
// until the single-cycle mem_ack; mem_we, mem_addr and mem_wdata are stable
// for the whole request and mem_rdata is sampled only with mem_ack.
module qspi_slave_cmd_ctrl
  import qspi_pkg::*;
#(
  parameter int         ADDR_BYTES = 2,
  parameter int         AW         = 16,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          sel,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_oe,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic [7:0]    status,
  output state_e        o_dbg_state
);

  state_e        r_state;
  logic          r_sel_d;
  logic          r_is_read;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic [7:0]    r_tx_data;
  logic          r_tx_oe;
  logic          r_overrun;
  logic          r_cmd_err;

  logic          w_busy;
  logic [7:0]    w_status;
  logic          w_ack;
  logic          w_addr_done;
  logic [AW-1:0] w_addr;

  assign w_busy = (r_state != ST_IDLE);
  // Only an ack that answers our own request counts.
  assign w_ack  = mem_ack && r_mem_req;

  // Assemble the status byte from the sticky flags and the busy indication.
  always_comb begin
    w_status               = '0;
    w_status[STAT_BUSY]    = w_busy;
    w_status[STAT_CMD_ERR] = r_cmd_err;
    w_status[STAT_OVERRUN] = r_overrun;
  end

  qspi_addr_collector #(
    .ADDR_BYTES (ADDR_BYTES),
    .AW         (AW)
  ) u_addr (
    .clk          (clk),
    .resetn       (resetn),
    .i_clear      (r_state != ST_ADDR),
    .i_byte_valid ((r_state == ST_ADDR) && rx_valid && sel),
    .i_byte       (rx_data),
    .o_addr       (w_addr),
    .o_done       (w_addr_done)
  );

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    // Follows sel even during reset so a select held across reset is not
    // mistaken for a new transaction.
    r_sel_d <= sel;
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_is_read   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tx_data   <= IDLE_BYTE;
      r_tx_oe     <= 1'b0;
      r_overrun   <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else if (r_state != ST_IDLE && !sel) begin
      // Deselect: an outstanding request must complete before going idle.
      if (r_mem_req && !mem_ack) begin
        r_state <= r_state;
      end else begin
        r_state   <= ST_IDLE;
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        r_tx_oe   <= 1'b0;
        r_tx_data <= IDLE_BYTE;
        if (r_state == ST_STAT) begin
          r_overrun <= 1'b0;
          r_cmd_err <= 1'b0;
        end
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sel && !r_sel_d) r_state <= ST_CMD;
        end
        ST_CMD: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_WRITE: begin
                r_is_read <= 1'b0;
                r_state   <= ST_ADDR;
              end
              CMD_READ: begin
                r_is_read <= 1'b1;
                r_state   <= ST_ADDR;
              end
              CMD_STATUS: begin
                r_tx_data <= w_status;
                r_tx_oe   <= 1'b1;
                r_state   <= ST_STAT;
              end
              default: begin
                r_cmd_err <= 1'b1;
                r_state   <= ST_DRAIN;
              end
            endcase
          end
        end
        ST_ADDR: begin
          if (w_addr_done) begin
            r_mem_addr <= w_addr;
            if (r_is_read) begin
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
              r_state   <= ST_RD_FETCH;
            end else begin
              r_state   <= ST_WR;
            end
          end
        end
        ST_WR: begin
          // A completing ack frees the port before a new byte is considered.
          if (w_ack) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= r_mem_addr + AW'(1);
          end
          if (rx_valid) begin
            if (r_mem_req && !mem_ack) begin
              r_overrun <= 1'b1;
            end else begin
              r_mem_wdata <= rx_data;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
            end
          end
        end
        ST_RD_FETCH: begin
          if (w_ack) begin
            r_tx_data  <= mem_rdata;
            r_tx_oe    <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_addr <= r_mem_addr + AW'(1);
            r_state    <= ST_RD_STREAM;
          end
        end
        ST_RD_STREAM: begin
          if (w_ack) begin
            r_tx_data  <= mem_rdata;
            r_mem_req  <= 1'b0;
            r_mem_addr <= r_mem_addr + AW'(1);
          end
          // Each consumed byte triggers the prefetch of the next one.
          if (tx_ready) begin
            if (r_mem_req && !mem_ack) begin
              r_overrun <= 1'b1;
            end else begin
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
            end
          end
        end
        ST_STAT, ST_DRAIN: begin
          r_state <= r_state;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_oe       = r_tx_oe;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = w_busy;
  assign status      = w_status;
  assign o_dbg_state = r_state;

endmodule
